// File: rtl/serdes_tx_serializer.sv
// Byte-to-serial transmitter: bytes are buffered in a FIFO and shifted out LSB first, with periodic sync-byte insertion.
// Build macro SERDES_TX_PARITY_EN appends an even-parity bit to every word (9-clock words).
module serdes_tx_serializer #(
    parameter int         FIFO_DEPTH    = 4,
    parameter logic [7:0] SYNC_BYTE     = 8'hA5,
    parameter int         SYNC_INTERVAL = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ena,
    input  logic [7:0]                  in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        ser_out,
    output logic                        ser_valid,
    output logic                        ser_first,
    output logic                        ser_is_sync,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (SYNC_INTERVAL > 32'sd1) ? $clog2(SYNC_INTERVAL + 32'sd1) : 1;
    localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
    localparam logic [CW-1:0] SYNC_LIMIT = CW'(SYNC_INTERVAL);
    localparam bit            SYNC_EN    = (SYNC_INTERVAL != 32'sd0);
`ifdef SERDES_TX_PARITY_EN
    localparam logic [3:0] LAST_BIT = 4'd8;
`else
    localparam logic [3:0] LAST_BIT = 4'd7;
`endif

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_SYNC  = 2'd2;

`ifdef SERDES_TX_PARITY_EN
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction
`endif

    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic [CW-1:0] sync_cnt_r;
    logic [1:0]    state_r;
    logic [3:0]    bit_cnt_r;
    logic [6:0]    shift_r;
    logic          ser_out_r;
    logic          ser_valid_r;
    logic          ser_first_r;
    logic          ser_is_sync_r;
`ifdef SERDES_TX_PARITY_EN
    logic          parity_r;
`endif

    logic          push_s;
    logic          pop_s;
    logic          empty_s;
    logic          sync_due_s;
    logic          boundary_s;
    logic          start_sync_s;
    logic          start_data_s;
    logic          stop_s;
    logic          step_s;
    logic [7:0]    head_s;
    logic [7:0]    load_byte_s;

    assign in_ready    = (level_r != LEVEL_FULL);
    assign fifo_level  = level_r;
    assign ser_out     = ser_out_r;
    assign ser_valid   = ser_valid_r;
    assign ser_first   = ser_first_r;
    assign ser_is_sync = ser_is_sync_r;

    assign push_s     = in_valid && in_ready;
    assign pop_s      = start_data_s;
    assign empty_s    = (level_r == {LW{1'b0}});
    assign head_s     = mem_r[rd_ptr_r];
    assign sync_due_s = SYNC_EN && (sync_cnt_r == SYNC_LIMIT);
    // Any state other than an active word is treated as a boundary so stray encodings fall back to IDLE.
    assign boundary_s = ((state_r != ST_SHIFT) && (state_r != ST_SYNC)) || (bit_cnt_r >= LAST_BIT);

    // Decide at each enabled edge whether to load a sync word, load data, go idle or shift on
    always_comb begin
        start_sync_s = 1'b0;
        start_data_s = 1'b0;
        stop_s       = 1'b0;
        step_s       = 1'b0;
        if (ena && boundary_s) begin
            if (sync_due_s && !empty_s) begin
                start_sync_s = 1'b1;
            end else if (!empty_s) begin
                start_data_s = 1'b1;
            end else begin
                stop_s = 1'b1;
            end
        end else if (ena) begin
            step_s = 1'b1;
        end else begin
            step_s = 1'b0;
        end
    end

    // Select the byte entering the shifter on a word load
    always_comb begin
        load_byte_s = head_s;
        if (start_sync_s) begin
            load_byte_s = SYNC_BYTE;
        end else begin
            load_byte_s = head_s;
        end
    end

    // FIFO storage; stale entries are harmless because the pointers are reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1'b1);
                2'b01:   level_r <= level_r - LW'(1'b1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Count data bytes popped since the last sync word; saturates at the interval
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_cnt_r <= {CW{1'b0}};
        end else if (start_sync_s) begin
            sync_cnt_r <= {CW{1'b0}};
        end else if (start_data_s && SYNC_EN && (sync_cnt_r != SYNC_LIMIT)) begin
            sync_cnt_r <= sync_cnt_r + CW'(1'b1);
        end
    end

    // Word state, shifter and registered serial outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            bit_cnt_r     <= 4'd0;
            shift_r       <= 7'h7F;
            ser_out_r     <= 1'b1;
            ser_valid_r   <= 1'b0;
            ser_first_r   <= 1'b0;
            ser_is_sync_r <= 1'b0;
`ifdef SERDES_TX_PARITY_EN
            parity_r      <= 1'b0;
`endif
        end else if (start_sync_s || start_data_s) begin
            state_r       <= start_sync_s ? ST_SYNC : ST_SHIFT;
            bit_cnt_r     <= 4'd0;
            shift_r       <= load_byte_s[7:1];
            ser_out_r     <= load_byte_s[0];
            ser_valid_r   <= 1'b1;
            ser_first_r   <= 1'b1;
            ser_is_sync_r <= start_sync_s;
`ifdef SERDES_TX_PARITY_EN
            parity_r      <= even_parity(load_byte_s);
`endif
        end else if (stop_s) begin
            state_r       <= ST_IDLE;
            bit_cnt_r     <= 4'd0;
            shift_r       <= 7'h7F;
            ser_out_r     <= 1'b1;
            ser_valid_r   <= 1'b0;
            ser_first_r   <= 1'b0;
            ser_is_sync_r <= 1'b0;
        end else if (step_s) begin
            bit_cnt_r   <= bit_cnt_r + 4'd1;
            shift_r     <= {1'b1, shift_r[6:1]};
            ser_first_r <= 1'b0;
`ifdef SERDES_TX_PARITY_EN
            if (bit_cnt_r == 4'd7) begin
                ser_out_r <= parity_r;
            end else begin
                ser_out_r <= shift_r[0];
            end
`else
            ser_out_r   <= shift_r[0];
`endif
        end
    end

endmodule
